// File: rtl/debug_unit_cmd.sv
// UART debug command decoder for the MIPS core: run/halt/step control,
// PC readback as little-endian bytes, echo of unknown bytes, RX overrun flag.
module debug_unit_cmd #(
    parameter int                DATA_W   = 8,
    parameter int                PC_W     = 10,
    parameter logic [DATA_W-1:0] CMD_RUN  = DATA_W'(8'h72),
    parameter logic [DATA_W-1:0] CMD_HALT = DATA_W'(8'h68),
    parameter logic [DATA_W-1:0] CMD_STEP = DATA_W'(8'h73),
    parameter logic [DATA_W-1:0] CMD_PC   = DATA_W'(8'h70)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] rx_dato_out,
    input  logic              rx_done,
    input  logic              tx_done,
    input  logic [PC_W-1:0]   PC_plus_1,
    output logic              enable,
    output logic [DATA_W-1:0] tx_dato_in,
    output logic              tx_start,
    output logic              busy,
    output logic              overrun
);

    localparam int NBYTES = (PC_W + DATA_W - 1) / DATA_W;
    localparam int SH_W   = NBYTES * DATA_W;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NBYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_SEND,
        S_WAIT,
        S_GAP
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_cmd;
    logic [SH_W-1:0]   r_shift;
    logic [IDX_W-1:0]  r_idx;
    logic              r_is_pc;
    logic              r_run;
    logic              r_step;
    logic              r_tx_start;
    logic [DATA_W-1:0] r_tx_dato;
    logic              r_overrun;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cmd      <= '0;
            r_shift    <= '0;
            r_idx      <= '0;
            r_is_pc    <= 1'b0;
            r_run      <= 1'b0;
            r_step     <= 1'b0;
            r_tx_start <= 1'b0;
            r_tx_dato  <= '0;
            r_overrun  <= 1'b0;
        end else begin
            r_step <= 1'b0;
            // A byte arriving outside IDLE is dropped, never queued.
            if (rx_done && (r_state != S_IDLE))
                r_overrun <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (rx_done) begin
                        r_cmd   <= rx_dato_out;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_is_pc <= 1'b0;
                    r_idx   <= '0;
                    r_shift <= SH_W'(r_cmd);
                    if (r_cmd == CMD_RUN) begin
                        r_run <= 1'b1;
                    end else if (r_cmd == CMD_HALT) begin
                        r_run <= 1'b0;
                    end else if (r_cmd == CMD_STEP) begin
                        r_run  <= 1'b0;
                        r_step <= 1'b1;
                    end else if (r_cmd == CMD_PC) begin
                        r_is_pc <= 1'b1;
                        r_shift <= SH_W'(PC_plus_1);
                    end
                    r_state <= S_SEND;
                end
                S_SEND: begin
                    r_tx_dato  <= r_shift[DATA_W-1:0];
                    r_tx_start <= 1'b1;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (tx_done) begin
                        r_tx_start <= 1'b0;
                        // Low byte goes first; shift the next one down.
                        if (r_is_pc && (r_idx != LAST)) begin
                            r_idx   <= r_idx + 1'b1;
                            r_shift <= r_shift >> DATA_W;
                            r_state <= S_GAP;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_GAP: begin
                    r_state <= S_SEND;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign enable     = r_run | r_step;
    assign tx_start   = r_tx_start;
    assign tx_dato_in = r_tx_dato;
    assign busy       = (r_state != S_IDLE);
    assign overrun    = r_overrun;

endmodule

// File: doc/debug_unit_cmd.md
Name: debug_unit_cmd

Overview:
Parametrised UART debug controller for the MIPS core, sitting between the UART RX/TX pair and the processor's `enable` input. It decodes single-byte host commands: run, halt, single-step and read PC. The PC read returns the PC as a multi-byte little-endian sequence. Any unrecognised byte is echoed back. Every byte that arrives while a transmit is in progress is dropped and flagged.

Parameters:
DATA_W, 8, UART data width in bits
PC_W, 10, width of PC_plus_1 in bits
CMD_RUN, 8'h72 ('r'), set continuous enable
CMD_HALT, 8'h68 ('h'), clear enable
CMD_STEP, 8'h73 ('s'), one-cycle enable pulse
CMD_PC, 8'h70 ('p'), transmit PC
(localparam NBYTES = ceil(PC_W/DATA_W); with the defaults this is 2)

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  asynchronous, active-low reset
rx_dato_out  in  DATA_W  received byte, valid in rx_done cycle
rx_done  in  1  one-cycle pulse, new RX byte
tx_done  in  1  one-cycle pulse, TX finished current byte
PC_plus_1  in  PC_W  current PC+1 from core
enable  out  1  processor clock enable
tx_dato_in  out  DATA_W  byte to transmit, stable while tx_start=1
tx_start  out  1  transmit request, level held until tx_done
busy  out  1  high in any state other than IDLE
overrun  out  1  sticky; set when an RX byte is dropped, cleared only by reset

Behaviour:
- Reset (async, rst_n=0): state=IDLE, enable=0, run mode=0, tx_start=0, tx_dato_in=0, overrun=0, byte index=0.
- States: IDLE, DECODE, SEND, WAIT_DONE, GAP.
- IDLE: on rx_done=1, latch rx_dato_out into cmd_reg -> DECODE.
- DECODE (one cycle; edge n+1 if rx_done is sampled at edge n):
  - CMD_RUN: run mode=1; echo cmd.
  - CMD_HALT: run mode=0; echo cmd.
  - CMD_STEP: run mode=0; step pulse armed; echo cmd.
  - CMD_PC: snapshot PC_plus_1 zero-extended to NBYTES*DATA_W into shift register; index=0.
  - Other: echo cmd.
  - All cases -> SEND.
- enable = run mode OR step pulse.
  - Step pulse is high for exactly one clk: the cycle after DECODE.
  - Step issued while running: enable stays 1 for that one cycle, then 0.
- SEND: load tx_dato_in (echo byte, or PC byte [index], least significant byte first); tx_start=1 -> WAIT_DONE.
  - tx_start therefore rises at edge n+2 after the rx_done sample.
- WAIT_DONE: hold tx_start=1 and tx_dato_in unchanged until tx_done=1.
  - On tx_done: tx_start=0.
  - If PC transfer and index<NBYTES-1: index++ -> GAP; else -> IDLE.
- GAP: one cycle with tx_start=0 (guarantees a rising edge per byte) -> SEND.
- Overrun: rx_done=1 in any state except IDLE -> byte discarded, overrun=1. State and outputs are otherwise unaffected.
- rx_done and tx_done in the same cycle in WAIT_DONE: tx_done is processed, the RX byte is dropped and overrun is set (the next state is not IDLE at that edge).
- tx_done outside WAIT_DONE: ignored.
- PC snapshot is taken in DECODE only; later PC changes do not alter bytes already queued.
- PC_W a multiple of DATA_W: no padding. Otherwise the upper bits of the last byte are 0.
- Reset asserted mid-transfer: immediate return to reset values.
  - tx_start drops asynchronously.
  - The partially sent PC sequence is abandoned, not resumed.

Test Plan:
1. Reset, then rx byte 8'h41 -> tx_start rises 2 clks after rx_done, tx_dato_in=8'h41, held until tx_done; enable stays 0; busy low afterwards.
2. Send 'r' -> enable=1 from DECODE+1 and stays 1; 'r' echoed. Then send 'h' -> enable=0 one cycle after DECODE; 'h' echoed.
3. Send 's' with enable=0 -> enable high for exactly 1 clk, 's' echoed. Repeat with run mode active -> one more enable cycle, then enable=0.
4. PC_plus_1=10'h2A5, send 'p' -> tx_dato_in=8'hA5, then tx_done, then 1 GAP cycle with tx_start=0, then tx_dato_in=8'h02; PC changed to 10'h001 during the transfer -> second byte still 8'h02.
5. During WAIT_DONE, pulse rx_done (8'h55), including once coincident with tx_done -> byte not echoed, overrun=1 and stays 1 until rst_n=0.
6. Assert rst_n=0 between the two PC bytes -> tx_start=0, enable=0, state IDLE immediately; after release, 'p' restarts from the low byte.
